ysyx_25020047_wbu: RTL and testbench
====================================

# ysyx_25020047_wbu

Write-back unit for the single-issue ysyx_25020047 core. It accepts one executed instruction per handshake from the execute stage, registers it for one cycle, and commits it: it writes the general-purpose register file, advances or redirects the PC, and stops the core on ebreak. It owns the GPR array and the architectural PC, and supplies the two combinational register read ports used by decode/execute.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- NR_REG, 32, number of GPRs; index 0 is hardwired to zero.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ex_valid  in  1  execute stage presents an instruction.
- ex_ready  out  1  WBU accepts it; a transfer occurs on the edge where ex_valid && ex_ready.
- ex_rd  in  5  destination register index.
- ex_result  in  32  value written to rd.
- ex_reg_wen  in  1  write rd on commit.
- ex_pc_wen  in  1  redirect the PC to ex_target on commit.
- ex_target  in  32  redirect target; bit 0 is forced to 0.
- ex_halt  in  1  instruction is ebreak.
- rs1_addr, rs2_addr  in  5 each  read addresses.
- rs1_data, rs2_data  out  32 each  read data.
- pc  out  32  architectural PC.
- commit_valid  out  1  pulses for one cycle when an instruction commits.
- halted  out  1  high once ebreak has committed.

## Operation
- The WBU has a one-entry stage register: wb_valid, rd, result, reg_wen, pc_wen, target, halt.
- State machine:
  - RUN: ex_ready = 1. A handshake loads the stage register and sets wb_valid. With no handshake, wb_valid clears.
  - HALT: ex_ready = 0; wb_valid stays 0. Only reset leaves HALT.
- Commit happens in every cycle with wb_valid = 1. At the end of that cycle:
  - Non-halt instruction:
    - if reg_wen and rd != 0, GPR[rd] <= result;
    - pc <= pc_wen ? {target[31:1],1'b0} : pc + 32'd4, wrapping modulo 2^32;
    - commit_valid = 1 during the cycle.
  - Halt instruction: no GPR write and no PC change; state goes to HALT; commit_valid = 1.
- Writes with rd = 0 are discarded, and rs*_data reads 0 whenever the address is 0.
- A new handshake may occur in the same cycle as a commit, which gives back-to-back throughput of one instruction per cycle.
- If the entry being committed is a halt, ex_ready is still 1 during that cycle. An instruction accepted in that cycle is loaded into the stage register but is discarded on the transition to HALT and never commits.
- If ex_halt and ex_pc_wen are both set, halt wins and the PC is unchanged.

## Timing
- Reset (rst_n = 0 at an edge):
  - pc = RESET_PC, state = RUN, wb_valid = 0, commit_valid = 0, halted = 0, ex_ready = 1.
  - GPR contents are reset to 0.
- Latency: handshake at edge N, commit during cycle N..N+1, GPR and PC updated at edge N+1.
- Reads are combinational from the array.
- Reset asserted while an instruction is in the stage register: that entry is dropped with no write, and the reset values apply at that edge.
- halted = 1 in the cycle after the halt commit and stays high until reset.

## Configuration
- YSYX_25020047_WB_BYPASS_EN:
  - Defined: when a commit writes GPR[rd] (rd != 0) and rs1_addr or rs2_addr equals rd in that same cycle, the matching rs*_data returns the committing result.
  - Undefined: rs*_data returns the old array value until the edge.

## Test plan
- Reset, then write: rst_n low for 2 cycles, then release.
  - pc = 32'h8000_0000, ex_ready = 1, halted = 0, and rs1_data = 0 for every address.
- Single write: handshake {rd=5, result=32'h1234_5678, reg_wen=1}.
  - At the next edge GPR5 = 32'h1234_5678, pc = 32'h8000_0004, and commit_valid is 1 for exactly one cycle.
- x0 protection: handshake {rd=0, result=32'hFFFF_FFFF, reg_wen=1}.
  - rs1_addr=0 reads 0.
  - pc still advances by 4.
- Redirect: handshake {pc_wen=1, target=32'h8000_0101, reg_wen=1, rd=1, result=32'h8000_0008}.
  - pc = 32'h8000_0100 and GPR1 = 32'h8000_0008.
- Back-to-back then halt: handshakes on three consecutive cycles, {rd=2,1}, {rd=3,2}, {halt=1}, plus a fourth valid {rd=4,4}.
  - GPR2 = 1, GPR3 = 2, GPR4 unchanged (0).
  - PC is unchanged by the halt commit.
  - halted = 1 and ex_ready = 0 until reset.
- Bypass: rs1_addr=7 while committing {rd=7, result=32'hA5A5_A5A5}.
  - With the macro defined, rs1_data = 32'hA5A5_A5A5 in the commit cycle.
  - Without it, rs1_data shows the old value; both cases show the new value afterwards.

Source files
------------

// File: rtl/ysyx_25020047_wbu.sv
// Write-back unit: one-entry stage register, GPR file, architectural PC and ebreak halt.
// Optional same-cycle read bypass of the committing result: YSYX_25020047_WB_BYPASS_EN.
module ysyx_25020047_wbu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned NR_REG   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        ex_reg_wen,
  input  logic        ex_pc_wen,
  input  logic [31:0] ex_target,
  input  logic        ex_halt,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] pc,
  output logic        commit_valid,
  output logic        halted
);

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic        reg_wen_q;
  logic        pc_wen_q;
  logic [31:0] target_q;
  logic        halt_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] gpr_q [NR_REG];

  logic handshake;
  logic commit_wr;
  logic unused_target_lsb;

  assign handshake         = ex_valid && ex_ready;
  assign commit_wr         = wb_valid_q && !halt_q && reg_wen_q && (rd_q != 5'd0);
  assign unused_target_lsb = target_q[0];

  assign ex_ready     = (state_q == StRun);
  assign commit_valid = wb_valid_q;
  assign halted       = (state_q == StHalt);
  assign pc           = pc_q;

  always_comb begin
    state_d    = state_q;
    wb_valid_d = 1'b0;
    pc_d       = pc_q;
    if (wb_valid_q) begin
      if (halt_q) begin
        state_d = StHalt;
      end else if (pc_wen_q) begin
        pc_d = {target_q[31:1], 1'b0};
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
    // An instruction accepted alongside a halt commit is dropped here.
    if ((state_q == StRun) && !(wb_valid_q && halt_q)) begin
      wb_valid_d = ex_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StRun;
      wb_valid_q <= 1'b0;
      pc_q       <= RESET_PC;
      rd_q       <= 5'd0;
      result_q   <= 32'd0;
      reg_wen_q  <= 1'b0;
      pc_wen_q   <= 1'b0;
      target_q   <= 32'd0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      pc_q       <= pc_d;
      if (handshake) begin
        rd_q      <= ex_rd;
        result_q  <= ex_result;
        reg_wen_q <= ex_reg_wen;
        pc_wen_q  <= ex_pc_wen;
        target_q  <= ex_target;
        halt_q    <= ex_halt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NR_REG; i++) begin
        gpr_q[i] <= 32'd0;
      end
    end else if (commit_wr) begin
      gpr_q[rd_q] <= result_q;
    end
  end

  always_comb begin
    rs1_data = (rs1_addr == 5'd0) ? 32'd0 : gpr_q[rs1_addr];
    rs2_data = (rs2_addr == 5'd0) ? 32'd0 : gpr_q[rs2_addr];
`ifdef YSYX_25020047_WB_BYPASS_EN
    if (commit_wr && (rs1_addr == rd_q)) rs1_data = result_q;
    if (commit_wr && (rs2_addr == rd_q)) rs2_data = result_q;
`endif
  end

endmodule

// File: tb/tb_ysyx_25020047_wbu.sv
// Self-checking bench for ysyx_25020047_wbu: vector table with a commit scoreboard,
// plus hand sequences for bypass, back-to-back halt and reset during a pending commit.
module tb_ysyx_25020047_wbu;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_reg_wen;
  logic        ex_pc_wen;
  logic [31:0] ex_target;
  logic        ex_halt;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] pc;
  logic        commit_valid;
  logic        halted;

  ysyx_25020047_wbu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_rd        (ex_rd),
    .ex_result    (ex_result),
    .ex_reg_wen   (ex_reg_wen),
    .ex_pc_wen    (ex_pc_wen),
    .ex_target    (ex_target),
    .ex_halt      (ex_halt),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .pc           (pc),
    .commit_valid (commit_valid),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] result;
    logic        reg_wen;
    logic        pc_wen;
    logic [31:0] target;
    logic [31:0] exp_pc;
    logic [31:0] exp_val;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] exp_pc;
    logic [31:0] exp_val;
  } sb_t;

  vec_t vecs [8];
  sb_t  sb_q [$];
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic clear_ex();
    ex_valid   = 1'b0;
    ex_rd      = 5'd0;
    ex_result  = 32'd0;
    ex_reg_wen = 1'b0;
    ex_pc_wen  = 1'b0;
    ex_target  = 32'd0;
    ex_halt    = 1'b0;
  endtask

  task automatic drive_ex(input logic [4:0] rd, input logic [31:0] res, input logic wen,
                          input logic pcw, input logic [31:0] tgt, input logic hlt);
    ex_valid   = 1'b1;
    ex_rd      = rd;
    ex_result  = res;
    ex_reg_wen = wen;
    ex_pc_wen  = pcw;
    ex_target  = tgt;
    ex_halt    = hlt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    sb_t e;
    @(posedge clk);
    #1;
    drive_ex(v.rd, v.result, v.reg_wen, v.pc_wen, v.target, 1'b0);
    sb_q.push_back('{rd: v.rd, exp_pc: v.exp_pc, exp_val: v.exp_val});
    check($sformatf("vec%0d_ready", idx), {31'd0, ex_ready}, 32'd1);
    @(posedge clk);
    #1;
    clear_ex();
    @(negedge clk);
    check($sformatf("vec%0d_commit", idx), {31'd0, commit_valid}, 32'd1);
    if (commit_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_pc", idx), pc, e.exp_pc);
      check($sformatf("vec%0d_pulse", idx), {31'd0, commit_valid}, 32'd0);
      rs2_addr = e.rd;
      #1;
      check($sformatf("vec%0d_gpr", idx), rs2_data, e.exp_val);
    end else begin
      @(posedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{5'd5,  32'h1234_5678, 1'b1, 1'b0, 32'h0,         32'h8000_0004, 32'h1234_5678};
    vecs[1] = '{5'd0,  32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,         32'h8000_0008, 32'h0};
    vecs[2] = '{5'd1,  32'h8000_0008, 1'b1, 1'b1, 32'h8000_0101, 32'h8000_0100, 32'h8000_0008};
    vecs[3] = '{5'd9,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         32'h8000_0104, 32'h0};
    vecs[4] = '{5'd10, 32'hCAFE_F00D, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hCAFE_F00D};
    vecs[5] = '{5'd11, 32'h0000_0011, 1'b1, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0011};
    vecs[6] = '{5'd5,  32'h5555_AAAA, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h5555_AAAA};
    vecs[7] = '{5'd7,  32'h1111_1111, 1'b1, 1'b0, 32'h0,         32'h8000_0004, 32'h1111_1111};

    clear_ex();
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    do_reset();
    #1;
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_ready", {31'd0, ex_ready}, 32'd1);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_commit", {31'd0, commit_valid}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = a[4:0];
      #1;
      check($sformatf("rst_gpr%0d", a), rs1_data, 32'd0);
    end
    rs1_addr = 5'd0;

    for (int i = 0; i < 8; i++) begin
      apply_vec(vecs[i], i);
    end
    rs1_addr = 5'd0;
    #1;
    check("x0_rs1", rs1_data, 32'd0);

    // Bypass: GPR7 holds 1111_1111, commit A5A5_A5A5 into it while reading rs1=7.
    @(posedge clk);
    #1;
    drive_ex(5'd7, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0, 1'b0);
    rs1_addr = 5'd7;
    @(posedge clk);
    #1;
    clear_ex();
    @(negedge clk);
    check("byp_commit", {31'd0, commit_valid}, 32'd1);
`ifdef YSYX_25020047_WB_BYPASS_EN
    check("byp_during", rs1_data, 32'hA5A5_A5A5);
`else
    check("byp_during", rs1_data, 32'h1111_1111);
`endif
    @(posedge clk);
    #1;
    check("byp_after", rs1_data, 32'hA5A5_A5A5);
    check("byp_pc", pc, 32'h8000_0008);
    rs1_addr = 5'd0;

    // Back-to-back writes, then a halt (with redirect and write requested), then a stray one.
    @(posedge clk);
    #1;
    drive_ex(5'd2, 32'd1, 1'b1, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    drive_ex(5'd3, 32'd2, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("b2b_c0", {31'd0, commit_valid}, 32'd1);
    @(posedge clk);
    #1;
    check("b2b_pc0", pc, 32'h8000_000C);
    drive_ex(5'd8, 32'h88, 1'b1, 1'b1, 32'h0000_1234, 1'b1);
    @(negedge clk);
    check("b2b_c1", {31'd0, commit_valid}, 32'd1);
    @(posedge clk);
    #1;
    check("b2b_pc1", pc, 32'h8000_0010);
    check("halt_ready_in_commit", {31'd0, ex_ready}, 32'd1);
    drive_ex(5'd4, 32'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("halt_commit", {31'd0, commit_valid}, 32'd1);
    check("halt_not_yet", {31'd0, halted}, 32'd0);
    @(posedge clk);
    #1;
    check("halt_pc", pc, 32'h8000_0010);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_ready", {31'd0, ex_ready}, 32'd0);
    @(negedge clk);
    check("halt_no_commit", {31'd0, commit_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    clear_ex();
    check("halt_stay", {31'd0, halted}, 32'd1);
    check("halt_stay_ready", {31'd0, ex_ready}, 32'd0);
    check("halt_stay_pc", pc, 32'h8000_0010);
    rs2_addr = 5'd2; #1; check("b2b_gpr2", rs2_data, 32'd1);
    rs2_addr = 5'd3; #1; check("b2b_gpr3", rs2_data, 32'd2);
    rs2_addr = 5'd4; #1; check("b2b_gpr4", rs2_data, 32'd0);
    rs2_addr = 5'd8; #1; check("halt_gpr8", rs2_data, 32'd0);

    // Reset while an entry sits in the stage register drops it.
    do_reset();
    #1;
    check("rst2_halted", {31'd0, halted}, 32'd0);
    check("rst2_ready", {31'd0, ex_ready}, 32'd1);
    rs2_addr = 5'd2; #1; check("rst2_gpr2", rs2_data, 32'd0);
    @(posedge clk);
    #1;
    drive_ex(5'd12, 32'h77, 1'b1, 1'b1, 32'h0000_4000, 1'b0);
    @(posedge clk);
    #1;
    clear_ex();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("drop_pc", pc, 32'h8000_0000);
    check("drop_commit", {31'd0, commit_valid}, 32'd0);
    rs2_addr = 5'd12; #1; check("drop_gpr12", rs2_data, 32'd0);
    @(posedge clk);
    #1;
    check("drop_pc_hold", pc, 32'h8000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
